fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the 5-stage MIPS core. Owns the fetch PC and the IF/ID instruction register, and drives the instruction-memory request handshake. Applies ID-stage branch/jump redirects after the delay slot, ID hazard stalls, and exception/ERET redirects, buffering or discarding in-flight fetches as needed. Its fetch address is the `delay_slot_pc` consumed by the ID-stage branch resolver.

## Interface
- RESET_PC, 32'h0040_0000, first fetch address after reset
- EXC_VECTOR, 32'h0040_0004, fetch address on `exc_req`
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- stall_id  in  1  ID hazard stall: hold IF/ID, `is_branch` not valid this cycle
- is_branch  in  1  ID instruction redirects (from branch resolver), qualified by `id_valid & ~stall_id`
- branch_pc  in  32  redirect target from branch resolver
- exc_req  in  1  exception redirect to EXC_VECTOR, flushes IF/ID
- eret_req  in  1  return redirect to `epc`, flushes IF/ID
- epc  in  32  ERET target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, also the delay-slot PC to ID
- imem_ready  in  1  fetch complete, `imem_rdata` valid; may assert in the request cycle
- imem_rdata  in  32  fetched instruction
- id_valid  out  1  IF/ID holds a live instruction
- id_instr  out  32  IF/ID instruction
- id_pc  out  32  IF/ID instruction address

## Operation
- Registers: `fetch_addr` (drives `imem_addr`), IF/ID triple, `buf_instr`, `pend_valid`, `pend_target`, state.
- States:
  - BOOT: reset state, `imem_req`=0, always goes to FETCH.
  - FETCH: `imem_req`=1.
  - HOLD: fetched word buffered, `imem_req`=0.
  - DISCARD: `imem_req`=1, stale request outstanding.
- `done` = FETCH & `imem_ready`.
- `next` = `branch_pc` if `is_branch & id_valid`; else `pend_target` if `pend_valid`; else `fetch_addr`+4, mod 2^32 wrap.
- Priority each cycle: redirect (`exc_req` over `eret_req`) > stall > normal.
- Redirect:
  - `fetch_addr`←target; `id_valid`←0; `pend_valid`←0.
  - State becomes DISCARD if a request is outstanding without `imem_ready` this cycle (FETCH or DISCARD), else FETCH.
  - HOLD buffer is dropped.
- Stall:
  - IF/ID holds.
  - FETCH & `done` → `buf_instr`←`imem_rdata`, go HOLD; `fetch_addr` unchanged.
- Normal, FETCH & `done`: IF/ID←{1, `imem_rdata`, `fetch_addr`}; `fetch_addr`←`next`; `pend_valid`←0.
- Normal, FETCH & ~`done`:
  - `id_valid`←0, i.e. a bubble.
  - If `is_branch & id_valid`: `pend_valid`←1, `pend_target`←`branch_pc`.
- Normal, HOLD: IF/ID←{1, `buf_instr`, `fetch_addr`}; `fetch_addr`←`next`; go FETCH.
- DISCARD & `imem_ready`: data dropped, go FETCH. `stall_id` is ignored in DISCARD.
- Handshake:
  - `imem_addr` is stable while `imem_req & ~imem_ready`.
  - A new address is presented only in the cycle after completion or redirect.
- The delay slot always executes: the redirect takes effect on the fetch following the slot.

## Timing
- Reset values:
  - state BOOT, `imem_req` 0, `imem_addr` RESET_PC.
  - `id_valid` 0, `id_instr` 0, `id_pc` 0.
  - `pend_valid` 0.
- First request is in the cycle after reset deasserts.
- Zero-wait memory gives 1 instruction/cycle. Fetch-to-IF/ID latency is 1 cycle after `imem_ready`.
- Redirect → new `imem_addr` the next cycle, unless DISCARD. DISCARD costs one extra cycle per outstanding-return cycle.
- `imem_ready` is ignored in BOOT and HOLD.
- Simultaneous redirect and stall: redirect wins.
- Reset mid-fetch: returns immediately to BOOT. The memory side must tolerate the abandoned request.

## Structure
- Shared core package holds:
  - `fetch_state_t` enum {BOOT, FETCH, HOLD, DISCARD}
  - defaults RESET_PC_DEFAULT and EXC_VECTOR_DEFAULT
  - INSTR_NOP = 32'h0
- No sub-module needed. The `next` mux may be a local function.

## Test plan
- Reset release, `imem_ready` tied 1 → `imem_addr` 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; `id_pc` lags by 1 cycle.
- Branch at 0x00400010, `is_branch`=1, `branch_pc`=0x00400100, zero-wait → slot 0x00400014 enters ID, then `imem_addr`=0x00400100.
- Same branch, `imem_ready` delayed 3 cycles on slot → `id_valid`=0 bubbles, `pend_valid`=1, next fetch 0x00400100.
- `stall_id`=1 for 2 cycles while 0x00400020 completes → HOLD, `imem_req`=0. After stall release: `id_pc`=0x00400020, next `imem_addr` 0x00400024.
- `exc_req` while 0x00400030 outstanding, ready 2 cycles later → DISCARD. Returned word is never seen on `id_valid`; next request 0x00400004.
- `eret_req` with `epc`=0x00400200 and `exc_req` same cycle → `exc_req` wins, `imem_addr`=EXC_VECTOR.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// default redirect addresses and the fetch-address selection helper.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,  // reset state, no request issued yet
        FETCH   = 2'd1,  // request live on the instruction-memory port
        HOLD    = 2'd2,  // fetched word parked while ID is stalled
        DISCARD = 2'd3   // stale request outstanding, its data is dropped
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0040_0004;
    localparam logic [31:0] INSTR_NOP          = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES        = 32'd4;

    // Address of the fetch that follows the current one. A branch resolved in
    // ID this cycle wins; otherwise a branch remembered during a fetch bubble;
    // otherwise sequential (32-bit add wraps naturally).
    function automatic logic [31:0] next_fetch_addr(
        input logic        take_branch,
        input logic [31:0] branch_pc,
        input logic        pend_valid,
        input logic [31:0] pend_target,
        input logic [31:0] fetch_addr
    );
        logic [31:0] addr;
        if (take_branch) begin
            addr = branch_pc;
        end else if (pend_valid) begin
            addr = pend_target;
        end else begin
            addr = fetch_addr + INSTR_BYTES;
        end
        return addr;
    endfunction

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC and the IF/ID register,
// drives the instruction-memory handshake, and applies branch (after the
// delay slot), stall, exception and ERET redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_id,
    input  logic        is_branch,
    input  logic [31:0] branch_pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    fetch_state_t state_q, state_d;
    logic         imem_req_q, imem_req_d;
    logic [31:0]  fetch_addr_q, fetch_addr_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_target_q, pend_target_d;

    logic         redirect;
    logic [31:0]  redirect_target;
    logic         outstanding;
    logic         done;
    logic         take_branch;
    logic [31:0]  next_addr;

    // Decode of the per-cycle control conditions shared by every state.
    always_comb begin
        redirect        = exc_req | eret_req;
        redirect_target = exc_req ? EXC_VECTOR : epc;
        outstanding     = (state_q == FETCH) || (state_q == DISCARD);
        done            = (state_q == FETCH) && imem_ready;
        // is_branch is only meaningful for a live, non-stalled ID instruction;
        // the stall case never reaches the paths that use this.
        take_branch     = is_branch & id_valid_q;
        next_addr       = next_fetch_addr(take_branch, branch_pc, pend_valid_q,
                                          pend_target_q, fetch_addr_q);
    end

    // Next-state logic: redirect beats stall, stall beats normal progress.
    always_comb begin
        // NOTE: every _d starts as its _q so that no path through the case
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        buf_instr_d   = buf_instr_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;

        if (redirect) begin
            // Flush IF/ID and any remembered branch; a request that is still
            // in flight must be drained before the new address is trusted.
            fetch_addr_d = redirect_target;
            id_valid_d   = 1'b0;
            pend_valid_d = 1'b0;
            state_d      = (outstanding && !imem_ready) ? DISCARD : FETCH;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = FETCH;
                end

                FETCH: begin
                    if (stall_id) begin
                        // IF/ID holds; a word that lands now is parked.
                        if (done) begin
                            buf_instr_d = imem_rdata;
                            state_d     = HOLD;
                        end
                    end else if (done) begin
                        id_valid_d   = 1'b1;
                        id_instr_d   = imem_rdata;
                        id_pc_d      = fetch_addr_q;
                        fetch_addr_d = next_addr;
                        pend_valid_d = 1'b0;
                    end else begin
                        // Bubble into ID. A branch leaving ID now still owns
                        // the slot being fetched, so remember its target.
                        id_valid_d = 1'b0;
                        if (take_branch) begin
                            pend_valid_d  = 1'b1;
                            pend_target_d = branch_pc;
                        end
                    end
                end

                HOLD: begin
                    if (!stall_id) begin
                        id_valid_d   = 1'b1;
                        id_instr_d   = buf_instr_q;
                        id_pc_d      = fetch_addr_q;
                        fetch_addr_d = next_addr;
                        pend_valid_d = 1'b0;
                        state_d      = FETCH;
                    end
                end

                DISCARD: begin
                    // Returned data belongs to the abandoned address; drop it.
                    if (imem_ready) begin
                        state_d = FETCH;
                    end
                end

                default: begin
                    state_d = BOOT;
                end
            endcase
        end

        imem_req_d = (state_d == FETCH) || (state_d == DISCARD);
    end

    // State, fetch PC, IF/ID triple and branch bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            imem_req_q    <= 1'b0;
            fetch_addr_q  <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= INSTR_NOP;
            id_pc_q       <= 32'h0;
            buf_instr_q   <= INSTR_NOP;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed above, independent of statement order.
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            fetch_addr_q  <= fetch_addr_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            buf_instr_q   <= buf_instr_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = fetch_addr_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, sequential fetch, branch with and
// without a slow delay slot, stall into HOLD, exception discard, priorities,
// address wrap and reset in the middle of a fetch.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_id;
    logic        is_branch;
    logic [31:0] branch_pc;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int errors = 0;
    int checks = 0;

    // Memory contents: a fixed, address-dependent pattern.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = instr_of(imem_addr);

    fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall_id   (stall_id),
        .is_branch  (is_branch),
        .branch_pc  (branch_pc),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc        (epc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move the fetch PC via an ERET redirect (memory is zero-wait here).
    task automatic jump_to(input logic [31:0] a);
        eret_req = 1'b1;
        epc      = a;
        step();
        eret_req = 1'b0;
        epc      = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_id = 1'b0; is_branch = 1'b0; branch_pc = 32'h0;
        exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0; imem_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rst_addr: got %h want 00400000", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", id_instr); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", id_pc); end
        step(); step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_hold_req: got %b want 0", imem_req); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL seq0: req %b addr %h want 1 00400000", imem_req, imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL seq0_valid: got %b want 0", id_valid); end
        step();
        checks++; if (imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL seq1_addr: got %h want 00400004", imem_addr); end
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0040_0000) begin errors++; $display("FAIL seq1_id: valid %b pc %h want 1 00400000", id_valid, id_pc); end
        checks++; if (id_instr !== 32'hA5E5_0000) begin errors++; $display("FAIL seq1_instr: got %h want a5e50000", id_instr); end
        step();
        checks++; if (imem_addr !== 32'h0040_0008 || id_pc !== 32'h0040_0004) begin errors++; $display("FAIL seq2: addr %h pc %h want 00400008 00400004", imem_addr, id_pc); end
    endtask

    task automatic test_branch_zero_wait();
        jump_to(32'h0040_0010);
        step();
        checks++; if (id_pc !== 32'h0040_0010 || imem_addr !== 32'h0040_0014) begin errors++; $display("FAIL bz_setup: pc %h addr %h want 00400010 00400014", id_pc, imem_addr); end
        is_branch = 1'b1; branch_pc = 32'h0040_0100;
        step();
        is_branch = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0040_0014) begin errors++; $display("FAIL bz_slot: valid %b pc %h want 1 00400014", id_valid, id_pc); end
        checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL bz_target: got %h want 00400100", imem_addr); end
        step();
        checks++; if (id_pc !== 32'h0040_0100 || imem_addr !== 32'h0040_0104) begin errors++; $display("FAIL bz_after: pc %h addr %h want 00400100 00400104", id_pc, imem_addr); end
    endtask

    task automatic test_branch_slow_slot();
        jump_to(32'h0040_0010);
        step();
        is_branch = 1'b1; branch_pc = 32'h0040_0100; imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            // Later is_branch pulses are unqualified (no live ID instruction).
            branch_pc = 32'h0040_0999;
            checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0014) begin
                errors++; $display("FAIL bs_wait%0d: valid %b req %b addr %h want 0 1 00400014", i, id_valid, imem_req, imem_addr);
            end
        end
        is_branch = 1'b0; imem_ready = 1'b1;
        step();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0040_0014) begin errors++; $display("FAIL bs_slot: valid %b pc %h want 1 00400014", id_valid, id_pc); end
        checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL bs_target: got %h want 00400100", imem_addr); end
        step();
        checks++; if (imem_addr !== 32'h0040_0104) begin errors++; $display("FAIL bs_seq: got %h want 00400104", imem_addr); end
    endtask

    task automatic test_stall_hold();
        jump_to(32'h0040_001C);
        step();
        stall_id = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0040_0020) begin errors++; $display("FAIL st_hold%0d: req %b addr %h want 0 00400020", i, imem_req, imem_addr); end
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0040_001C) begin errors++; $display("FAIL st_idhold%0d: valid %b pc %h want 1 0040001c", i, id_valid, id_pc); end
        end
        stall_id = 1'b0;
        step();
        checks++; if (id_pc !== 32'h0040_0020 || id_instr !== 32'hA5E5_0020) begin errors++; $display("FAIL st_release: pc %h instr %h want 00400020 a5e50020", id_pc, id_instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0024) begin errors++; $display("FAIL st_next: req %b addr %h want 1 00400024", imem_req, imem_addr); end
        step();
        checks++; if (id_pc !== 32'h0040_0024 || imem_addr !== 32'h0040_0028) begin errors++; $display("FAIL st_after: pc %h addr %h want 00400024 00400028", id_pc, imem_addr); end
    endtask

    task automatic test_exc_discard();
        jump_to(32'h0040_0030);
        imem_ready = 1'b0;
        step();
        exc_req = 1'b1;
        step();
        exc_req = 1'b0; stall_id = 1'b1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004 || id_valid !== 1'b0) begin
            errors++; $display("FAIL ex_discard: req %b addr %h valid %b want 1 00400004 0", imem_req, imem_addr, id_valid);
        end
        step();
        imem_ready = 1'b1;
        step();
        stall_id = 1'b0;
        // Stale word returned here; state moves on despite the stall request.
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin
            errors++; $display("FAIL ex_drop: valid %b req %b addr %h want 0 1 00400004", id_valid, imem_req, imem_addr);
        end
        step();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0040_0004 || id_instr !== 32'hA5E5_0004) begin
            errors++; $display("FAIL ex_first: valid %b pc %h instr %h want 1 00400004 a5e50004", id_valid, id_pc, id_instr);
        end
        checks++; if (imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL ex_seq: got %h want 00400008", imem_addr); end
    endtask

    task automatic test_priority();
        exc_req = 1'b1; eret_req = 1'b1; epc = 32'h0040_0200; stall_id = 1'b1;
        step();
        exc_req = 1'b0; eret_req = 1'b0; stall_id = 1'b0;
        checks++; if (imem_addr !== 32'h0040_0004 || imem_req !== 1'b1 || id_valid !== 1'b0) begin
            errors++; $display("FAIL pr_exc: addr %h req %b valid %b want 00400004 1 0", imem_addr, imem_req, id_valid);
        end
        eret_req = 1'b1; stall_id = 1'b1;
        step();
        eret_req = 1'b0; stall_id = 1'b0;
        checks++; if (imem_addr !== 32'h0040_0200 || imem_req !== 1'b1) begin errors++; $display("FAIL pr_eret_stall: addr %h req %b want 00400200 1", imem_addr, imem_req); end
        step();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0040_0200) begin errors++; $display("FAIL pr_eret_id: valid %b pc %h want 1 00400200", id_valid, id_pc); end
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFFC);
        step();
        checks++; if (id_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap: pc %h addr %h want fffffffc 00000000", id_pc, imem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        imem_ready = 1'b0;
        step();
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0040_0000 || id_valid !== 1'b0) begin
            errors++; $display("FAIL rm_reset: req %b addr %h valid %b want 0 00400000 0", imem_req, imem_addr, id_valid);
        end
        imem_ready = 1'b1;
        step();
        reset = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rm_restart: req %b addr %h want 1 00400000", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_zero_wait();
        test_branch_slow_slot();
        test_stall_hold();
        test_exc_discard();
        test_priority();
        test_wrap();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_ctrl
